// File: rtl/bcd_to_binary.sv
// Iterative 3-digit BCD to 8-bit binary converter (reverse double-dabble).
// START/BUSY/DONE handshake; one conversion every 12 cycles at best.
module bcd_to_binary #(
    parameter bit OVF_SAT = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [1:0] hundreds,
    input  logic [3:0] tens,
    input  logic [3:0] ones,
    output logic [7:0] bin,
    output logic       err,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

    state_t      state;
    logic [9:0]  bcd;
    logic [9:0]  acc;
    logic [3:0]  cnt;
    logic        bad_digit;

    logic [19:0] shifted;
    logic [9:0]  bcd_nxt;
    logic [9:0]  acc_nxt;

    // One reverse double-dabble step: shift right, then pull each
    // decimal field back into 0..9 range by subtracting 3 when >= 8.
    always_comb begin
        shifted = {bcd, acc} >> 1;
        bcd_nxt = shifted[19:10];
        acc_nxt = shifted[9:0];
        if (bcd_nxt[7:4] >= 4'd8) bcd_nxt[7:4] = bcd_nxt[7:4] - 4'd3;
        if (bcd_nxt[3:0] >= 4'd8) bcd_nxt[3:0] = bcd_nxt[3:0] - 4'd3;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            bcd       <= '0;
            acc       <= '0;
            cnt       <= '0;
            bad_digit <= 1'b0;
            bin       <= '0;
            err       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        bcd       <= {hundreds, tens, ones};
                        acc       <= '0;
                        cnt       <= '0;
                        bad_digit <= (tens > 4'd9) || (ones > 4'd9);
                        busy      <= 1'b1;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    bcd <= bcd_nxt;
                    acc <= acc_nxt;
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'd9) state <= FINISH;
                end
                FINISH: begin
                    if (bad_digit) begin
                        bin <= '0;
                        err <= 1'b1;
                    end else if (acc > 10'd255) begin
                        bin <= OVF_SAT ? 8'hFF : acc[7:0];
                        err <= 1'b1;
                    end else begin
                        bin <= acc[7:0];
                        err <= 1'b0;
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_to_binary.sv
// Self-checking bench: saturating and wrapping instances side by side,
// checked against a decimal-arithmetic reference model.
module tb_bcd_to_binary;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [1:0] hundreds = '0;
    logic [3:0] tens = '0;
    logic [3:0] ones = '0;
    logic [7:0] bin_s, bin_w;
    logic       err_s, err_w, busy_s, busy_w, done_s, done_w;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    bcd_to_binary #(.OVF_SAT(1'b1)) dut_sat (
        .clk(clk), .rst_n(rst_n), .start(start), .hundreds(hundreds),
        .tens(tens), .ones(ones), .bin(bin_s), .err(err_s),
        .busy(busy_s), .done(done_s)
    );

    bcd_to_binary #(.OVF_SAT(1'b0)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .start(start), .hundreds(hundreds),
        .tens(tens), .ones(ones), .bin(bin_w), .err(err_w),
        .busy(busy_w), .done(done_w)
    );

    // Reference: plain decimal value, then the result policy.
    task automatic ref_conv(input logic [1:0] h, input logic [3:0] t, input logic [3:0] o,
                            input bit sat, output logic [7:0] rb, output logic re);
        int v;
        v = int'(h) * 100 + int'(t) * 10 + int'(o);
        if (t > 4'd9 || o > 4'd9) begin
            rb = 8'h00; re = 1'b1;
        end else if (v > 255) begin
            rb = sat ? 8'hFF : 8'(v); re = 1'b1;
        end else begin
            rb = 8'(v); re = 1'b0;
        end
    endtask

    // Drives one conversion; lat = edges after the accepting edge until DONE.
    task automatic run_conv(input logic [1:0] h, input logic [3:0] t, input logic [3:0] o,
                            output int lat, output int bc,
                            output logic [7:0] bs, output logic es,
                            output logic [7:0] bw, output logic ew);
        @(negedge clk);
        hundreds = h; tens = t; ones = o; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        hundreds = 2'($urandom); tens = 4'($urandom); ones = 4'($urandom);
        lat = 0; bc = 0;
        while (!done_s && lat < 40) begin
            if (busy_s) bc++;
            @(negedge clk);
            lat++;
        end
        bs = bin_s; es = err_s; bw = bin_w; ew = err_w;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #12;
        total++;
        if ({bin_s, err_s, busy_s, done_s, bin_w, err_w, busy_w, done_w} !== 20'h0) begin
            bad++;
            $display("FAIL reset_state got bin=%h err=%b busy=%b done=%b need all 0",
                     bin_s, err_s, busy_s, done_s);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic;
        int lat, bc;
        logic [7:0] bs, bw;
        logic es, ew;
        run_conv(2'd1, 4'd3, 4'd7, lat, bc, bs, es, bw, ew);
        total++;
        if (lat !== 11) begin bad++; $display("FAIL basic_latency got %0d need 11", lat); end
        total++;
        if (bc !== 11) begin bad++; $display("FAIL basic_busy_cycles got %0d need 11", bc); end
        total++;
        if (bs !== 8'h89 || es !== 1'b0) begin
            bad++; $display("FAIL basic_137 got bin=%h err=%b need 89/0", bs, es);
        end
        @(negedge clk);
        total++;
        if (done_s !== 1'b0 || busy_s !== 1'b0 || bin_s !== 8'h89) begin
            bad++; $display("FAIL basic_done_pulse got done=%b busy=%b bin=%h need 0/0/89",
                            done_s, busy_s, bin_s);
        end
    endtask

    task automatic test_values;
        logic [1:0] hv [3] = '{2'd2, 2'd0, 2'd1};
        logic [3:0] tv [3] = '{4'd5, 4'd0, 4'd9};
        logic [3:0] ov [3] = '{4'd5, 4'd0, 4'd9};
        int lat, bc;
        logic [7:0] bs, bw, rb;
        logic es, ew, re;
        for (int i = 0; i < 3; i++) begin
            run_conv(hv[i], tv[i], ov[i], lat, bc, bs, es, bw, ew);
            ref_conv(hv[i], tv[i], ov[i], 1'b1, rb, re);
            total++;
            if (lat !== 11 || bs !== rb || es !== re) begin
                bad++;
                $display("FAIL values_%0d%0d%0d got lat=%0d bin=%h err=%b need 11/%h/%b",
                         hv[i], tv[i], ov[i], lat, bs, es, rb, re);
            end
        end
    endtask

    task automatic test_overflow;
        logic [1:0] hv [2] = '{2'd2, 2'd3};
        logic [3:0] tv [2] = '{4'd5, 4'd9};
        logic [3:0] ov [2] = '{4'd6, 4'd9};
        int lat, bc;
        logic [7:0] bs, bw, rs, rw;
        logic es, ew, res, rew;
        for (int i = 0; i < 2; i++) begin
            run_conv(hv[i], tv[i], ov[i], lat, bc, bs, es, bw, ew);
            ref_conv(hv[i], tv[i], ov[i], 1'b1, rs, res);
            ref_conv(hv[i], tv[i], ov[i], 1'b0, rw, rew);
            total++;
            if (bs !== rs || es !== res) begin
                bad++; $display("FAIL ovf_sat_%0d got bin=%h err=%b need %h/%b", i, bs, es, rs, res);
            end
            total++;
            if (bw !== rw || ew !== rew) begin
                bad++; $display("FAIL ovf_wrap_%0d got bin=%h err=%b need %h/%b", i, bw, ew, rw, rew);
            end
        end
    endtask

    task automatic test_bad_digit;
        logic [3:0] tv [2] = '{4'hA, 4'd1};
        logic [3:0] ov [2] = '{4'd2, 4'hF};
        int lat, bc;
        logic [7:0] bs, bw;
        logic es, ew;
        for (int i = 0; i < 2; i++) begin
            run_conv(2'd0, tv[i], ov[i], lat, bc, bs, es, bw, ew);
            total++;
            if (lat !== 11 || bc !== 11 || bs !== 8'h00 || es !== 1'b1 || bw !== 8'h00 || ew !== 1'b1) begin
                bad++;
                $display("FAIL bad_digit_%0d got lat=%0d busy=%0d bin=%h err=%b need 11/11/00/1",
                         i, lat, bc, bs, es);
            end
        end
    endtask

    task automatic test_random;
        int lat, bc;
        logic [1:0] h;
        logic [3:0] t, o;
        logic [7:0] bs, bw, rs, rw;
        logic es, ew, res, rew;
        for (int i = 0; i < 24; i++) begin
            h = 2'($urandom);
            t = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
            o = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
            run_conv(h, t, o, lat, bc, bs, es, bw, ew);
            ref_conv(h, t, o, 1'b1, rs, res);
            ref_conv(h, t, o, 1'b0, rw, rew);
            total++;
            if (lat !== 11 || bs !== rs || es !== res || bw !== rw || ew !== rew) begin
                bad++;
                $display("FAIL random_%0d in=%0d/%0d/%0d got lat=%0d sat=%h/%b wrap=%h/%b need 11 %h/%b %h/%b",
                         i, h, t, o, lat, bs, es, bw, ew, rs, res, rw, rew);
            end
        end
    endtask

    // START held high with digits changing every cycle; model accepts a
    // request only once the previous 12-cycle slot has elapsed.
    task automatic test_back_to_back;
        logic [1:0] qh [$];
        logic [3:0] qt [$];
        logic [3:0] qo [$];
        int accept_edge [$];
        int next_ok = 0;
        int dones = 0;
        logic exp_done;
        logic [7:0] rs;
        logic res;
        for (int e = 0; e < 62; e++) begin
            @(negedge clk);
            start = 1'b1;
            hundreds = 2'($urandom); tens = 4'($urandom_range(0, 10)); ones = 4'($urandom_range(0, 10));
            if (e >= next_ok) begin
                qh.push_back(hundreds); qt.push_back(tens); qo.push_back(ones);
                accept_edge.push_back(e);
                next_ok = e + 12;
            end
            #1;
            // outputs here reflect edge e-1
            exp_done = (accept_edge.size() > 0) && (accept_edge[0] + 11 == e - 1);
            total++;
            if (done_s !== exp_done) begin
                bad++; $display("FAIL b2b_done_edge%0d got %b need %b", e - 1, done_s, exp_done);
            end
            if (exp_done) begin
                ref_conv(qh[0], qt[0], qo[0], 1'b1, rs, res);
                dones++;
                total++;
                if (bin_s !== rs || err_s !== res) begin
                    bad++; $display("FAIL b2b_result_%0d got bin=%h err=%b need %h/%b",
                                    dones, bin_s, err_s, rs, res);
                end
                void'(qh.pop_front()); void'(qt.pop_front()); void'(qo.pop_front());
                void'(accept_edge.pop_front());
            end
        end
        @(negedge clk);
        start = 1'b0;
        total++;
        if (dones !== 5) begin bad++; $display("FAIL b2b_done_count got %0d need 5", dones); end
        repeat (14) @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int lat, bc, seen;
        logic [7:0] bs, bw;
        logic es, ew;
        @(negedge clk);
        hundreds = 2'd1; tens = 4'd2; ones = 4'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (busy_s !== 1'b0 || bin_s !== 8'h00 || err_s !== 1'b0 || done_s !== 1'b0) begin
            bad++; $display("FAIL midreset_clear got busy=%b bin=%h err=%b done=%b need 0/00/0/0",
                            busy_s, bin_s, err_s, done_s);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (done_s || busy_s) seen++;
        end
        total++;
        if (seen !== 0) begin bad++; $display("FAIL midreset_no_done got %0d active cycles need 0", seen); end
        run_conv(2'd2, 4'd4, 4'd6, lat, bc, bs, es, bw, ew);
        total++;
        if (lat !== 11 || bs !== 8'd246 || es !== 1'b0) begin
            bad++; $display("FAIL midreset_recover got lat=%0d bin=%h err=%b need 11/f6/0", lat, bs, es);
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_values;
        test_overflow;
        test_bad_digit;
        test_random;
        test_back_to_back;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
